// File: rtl/usb_fs_rx_if.sv
`timescale 1ns/1ps
// Decoded receive stream from the full-speed USB PHY to the packet layer.
// Strobe-only: the consumer must accept every pulse, there is no backpressure.
interface usb_fs_rx_if;
    logic bit_strobe;
    logic rx_active;
    logic rx_valid;
    logic rx_bit;
    logic rx_eop;
    logic rx_err;

    modport master (
        output bit_strobe, rx_active, rx_valid, rx_bit, rx_eop, rx_err
    );

    modport slave (
        input bit_strobe, rx_active, rx_valid, rx_bit, rx_eop, rx_err
    );
endinterface

// File: rtl/usb_fs_rx_phy.sv
`timescale 1ns/1ps
// Full-speed USB RX front end: pin sync, phase-accumulator bit recovery, NRZI, SYNC, unstuff, EOP.
// rx_valid/rx_eop/rx_err one clk50 after bit_strobe; no backpressure, the packet layer must take every pulse.
module usb_fs_rx_phy #(
    parameter int PH_INC       = 12,
    parameter int PH_MOD       = 50,
    parameter int PH_EDGE      = 12,
    parameter int MAX_SE0_BITS = 3
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic        dp,
    input  logic        dm,
    usb_fs_rx_if.master rx
);

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    localparam logic [6:0] INC7    = 7'(PH_INC);
    localparam logic [6:0] MOD7    = 7'(PH_MOD);
    localparam logic [6:0] HALF7   = 7'(PH_MOD / 2);
    localparam logic [5:0] EDGE6   = 6'(PH_EDGE);
    localparam logic [2:0] SE0_MAX = 3'(MAX_SE0_BITS);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ABORT} state_e;

    logic       dp_s1_q, dp_s2_q, dm_s1_q, dm_s2_q;
    logic [1:0] line_st, ls_prev_q, ls_prev_d, samp_q, samp_d;
    logic [5:0] acc_q, acc_d;
    logic [6:0] acc_sum;
    logic       is_jk, prev_jk, jk_edge, strobe, nrzi_one;
    state_e     state_q, state_d;
    logic [2:0] zcnt_q, zcnt_d, ones_q, ones_d, se0_q, se0_d;
    logic       active_q, active_d, valid_q, valid_d, bit_q, bit_d;
    logic       eop_q, eop_d, err_q, err_d;

    // Synchronisers power up at J so reset never looks like a line edge.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            dp_s1_q <= 1'b1;
            dp_s2_q <= 1'b1;
            dm_s1_q <= 1'b0;
            dm_s2_q <= 1'b0;
        end else begin
            dp_s1_q <= dp;
            dp_s2_q <= dp_s1_q;
            dm_s1_q <= dm;
            dm_s2_q <= dm_s1_q;
        end
    end

    assign line_st   = {dp_s2_q, dm_s2_q};
    assign is_jk     = line_st[1] ^ line_st[0];
    assign prev_jk   = ls_prev_q[1] ^ ls_prev_q[0];
    assign jk_edge   = is_jk && prev_jk && (line_st != ls_prev_q);
    assign acc_sum   = {1'b0, acc_q} + INC7;
    assign strobe    = ({1'b0, acc_q} < HALF7) && (acc_sum >= HALF7) && !jk_edge;
    assign nrzi_one  = (line_st == samp_q);
    assign ls_prev_d = line_st;

    always_comb begin
        if (jk_edge) begin
            acc_d = EDGE6;
        end else if (acc_sum >= MOD7) begin
            acc_d = 6'(acc_sum - MOD7);
        end else begin
            acc_d = acc_q + 6'(PH_INC);
        end
    end

    always_comb begin
        state_d  = state_q;
        zcnt_d   = zcnt_q;
        ones_d   = ones_q;
        se0_d    = se0_q;
        samp_d   = samp_q;
        active_d = active_q;
        valid_d  = 1'b0;
        bit_d    = 1'b0;
        eop_d    = 1'b0;
        err_d    = 1'b0;
        if (strobe) begin
            if (is_jk) samp_d = line_st;
            case (state_q)
                S_IDLE: begin
                    if (line_st == LS_K) begin
                        state_d = S_SYNC;
                        zcnt_d  = 3'd1;
                    end
                end
                S_SYNC: begin
                    if (!is_jk) begin
                        state_d = S_IDLE;
                    end else if (nrzi_one) begin
                        if (zcnt_q >= 3'd5) begin
                            state_d  = S_DATA;
                            active_d = 1'b1;
                            ones_d   = 3'd1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (zcnt_q != 3'd7) begin
                        zcnt_d = zcnt_q + 3'd1;
                    end
                end
                S_DATA: begin
                    if (line_st == LS_SE0) begin
                        state_d = S_EOP;
                        se0_d   = 3'd1;
                    end else if (line_st == LS_SE1) begin
                        err_d = 1'b1;
                    end else if (nrzi_one) begin
                        if (ones_q == 3'd6) begin
                            err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            bit_d   = 1'b1;
                            ones_d  = ones_q + 3'd1;
                        end
                    end else begin
                        // A zero after six ones is the stuffed bit and is dropped.
                        valid_d = (ones_q != 3'd6);
                        ones_d  = 3'd0;
                    end
                end
                S_EOP: begin
                    if (line_st == LS_SE0) begin
                        if (se0_q >= SE0_MAX) err_d = 1'b1;
                        else                  se0_d = se0_q + 3'd1;
                    end else if (line_st == LS_J) begin
                        eop_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_ABORT: begin
                    // se0_q doubles as the "SE0 seen" flag while aborted.
                    if (line_st == LS_SE0)                     se0_d   = 3'd1;
                    else if (line_st == LS_J && se0_q != 3'd0) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            if (err_d) begin
                state_d  = S_ABORT;
                active_d = 1'b0;
                se0_d    = 3'd0;
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            ls_prev_q <= LS_J;
            samp_q    <= LS_J;
            acc_q     <= 6'd0;
            state_q   <= S_IDLE;
            zcnt_q    <= 3'd0;
            ones_q    <= 3'd0;
            se0_q     <= 3'd0;
            active_q  <= 1'b0;
            valid_q   <= 1'b0;
            bit_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ls_prev_q <= ls_prev_d;
            samp_q    <= samp_d;
            acc_q     <= acc_d;
            state_q   <= state_d;
            zcnt_q    <= zcnt_d;
            ones_q    <= ones_d;
            se0_q     <= se0_d;
            active_q  <= active_d;
            valid_q   <= valid_d;
            bit_q     <= bit_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
        end
    end

    assign rx.bit_strobe = strobe;
    assign rx.rx_active  = active_q;
    assign rx.rx_valid   = valid_q;
    assign rx.rx_bit     = bit_q;
    assign rx.rx_eop     = eop_q;
    assign rx.rx_err     = err_q;

endmodule

// File: tb/tb_usb_fs_rx_phy.sv
`timescale 1ns/1ps
// Bench for usb_fs_rx_phy: drives timed D+/D- waveforms built from data bits and checks the decoded
// event stream against expectations derived from those data bits.
module tb_usb_fs_rx_phy;

    localparam int PH_INC = 12;
    localparam int PH_MOD = 50;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam int EV_VALID = 0;
    localparam int EV_EOP   = 1;
    localparam int EV_NONE  = 3;
    localparam int EV_ERR   = 2;
    localparam real NOM_NS  = 1000.0 / 12.0;

    typedef struct {
        int kind;
        bit b;
    } ev_t;

    logic clk50 = 1'b0;
    logic rst_n = 1'b0;
    logic dp = 1'b1;
    logic dm = 1'b0;

    usb_fs_rx_if rx_if();

    usb_fs_rx_phy #(
        .PH_INC(PH_INC), .PH_MOD(PH_MOD), .PH_EDGE(12), .MAX_SE0_BITS(3)
    ) dut (
        .clk50(clk50),
        .rst_n(rst_n),
        .dp(dp),
        .dm(dm),
        .rx(rx_if)
    );

    always #10 clk50 = ~clk50;

    int  n_cmp = 0;
    int  n_fail = 0;
    int  n_valid = 0;
    ev_t exp_q[$];
    bit  tx_bits[$];
    real bit_ns = NOM_NS;
    bit  strobe_prev = 1'b0;
    bit  active_seen = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] outs();
        return {rx_if.bit_strobe, rx_if.rx_active, rx_if.rx_valid,
                rx_if.rx_bit, rx_if.rx_eop, rx_if.rx_err};
    endfunction

    task automatic push_ev(input int kind, input bit b);
        ev_t e;
        e.kind = kind;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    // Compare process: every decoded event must match the next expectation in order.
    always @(negedge clk50) begin
        int nev, kind_act, kind_exp;
        bit b_exp;
        if (!rst_n) begin
            chk("reset_outputs", int'(outs()), 0);
            strobe_prev = 1'b0;
        end else begin
            nev = int'(rx_if.rx_valid) + int'(rx_if.rx_eop) + int'(rx_if.rx_err);
            if (rx_if.rx_active) active_seen = 1'b1;
            if (nev != 0) begin
                chk("one_hot", nev, 1);
                chk("strobe_to_out", int'(strobe_prev), 1);
                kind_act = rx_if.rx_valid ? EV_VALID : (rx_if.rx_eop ? EV_EOP : EV_ERR);
                if (exp_q.size() == 0) begin
                    kind_exp = EV_NONE;
                    b_exp    = 1'b0;
                end else begin
                    kind_exp = exp_q[0].kind;
                    b_exp    = exp_q[0].b;
                    void'(exp_q.pop_front());
                end
                chk("event_kind", kind_act, kind_exp);
                if (rx_if.rx_valid) begin
                    chk("rx_bit", int'(rx_if.rx_bit), int'(b_exp));
                    chk("active_with_valid", int'(rx_if.rx_active), 1);
                    n_valid++;
                end else begin
                    chk("active_after_end", int'(rx_if.rx_active), 0);
                end
            end
            strobe_prev = rx_if.bit_strobe;
        end
    end

    task automatic put(input logic [1:0] s);
        {dp, dm} = s;
        #(bit_ns);
    endtask

    task automatic idle(input int nbits);
        repeat (nbits) put(J);
    endtask

    task automatic load_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) tx_bits.push_back(v[i]);
    endtask

    task automatic expect_tx_bits();
        foreach (tx_bits[i]) push_ev(EV_VALID, tx_bits[i]);
    endtask

    // SYNC, NRZI-encoded tx_bits (optionally stuffed after six wire ones), n_se0 SE0s, then J.
    task automatic send_frame(input bit stuff_en, input int n_se0);
        logic [1:0] lvl;
        int ones;
        put(K); put(J); put(K); put(J); put(K); put(J); put(K); put(K);
        lvl  = K;
        ones = 1;
        foreach (tx_bits[i]) begin
            if (tx_bits[i]) ones++;
            else begin
                lvl  = ~lvl;
                ones = 0;
            end
            put(lvl);
            if (stuff_en && ones == 6) begin
                lvl  = ~lvl;
                ones = 0;
                put(lvl);
            end
        end
        repeat (n_se0) put(SE0);
        put(J);
        tx_bits.delete();
    endtask

    task automatic end_scn(input string nm, input int want_active);
        idle(4);
        repeat (10) @(negedge clk50);
        chk({nm, "_drain"}, exp_q.size(), 0);
        chk({nm, "_active_seen"}, int'(active_seen), want_active);
        exp_q.delete();
        active_seen = 1'b0;
    endtask

    task automatic a5_packet(input real f, input string nm);
        bit a5[8];
        a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit_ns = NOM_NS * f;
        idle(5);
        foreach (a5[i]) push_ev(EV_VALID, a5[i]);
        push_ev(EV_EOP, 1'b0);
        load_byte(8'hA5);
        send_frame(1'b1, 2);
        end_scn(nm, 1);
        bit_ns = NOM_NS;
    endtask

    task automatic run_random(input string nm);
        int nb;
        real f;
        logic [7:0] v;
        case ($urandom_range(0, 2))
            0:       f = 1.0;
            1:       f = 1.0025;
            default: f = 0.9975;
        endcase
        bit_ns = NOM_NS * f;
        idle($urandom_range(3, 10));
        #($urandom_range(0, 80000) / 1000.0);
        nb = $urandom_range(1, 4);
        repeat (nb) begin
            v = ($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom);
            load_byte(v);
        end
        expect_tx_bits();
        push_ev(EV_EOP, 1'b0);
        send_frame(1'b1, 2);
        end_scn(nm, 1);
        bit_ns = NOM_NS;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, last, base, wcnt;
        bit exp_s;
        {dp, dm} = J;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk50);
        rst_n = 1'b1;

        // Free-running phase with a quiet line: strobe where phase crosses mid-bit.
        cnt  = 0;
        last = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk50);
            exp_s = ((PH_INC * n + PH_MOD / 2 + PH_INC) / PH_MOD) > ((PH_INC * n + PH_MOD / 2) / PH_MOD);
            chk("idle_strobe", int'(rx_if.bit_strobe), int'(exp_s));
            if (rx_if.bit_strobe) begin
                if (cnt == 0) chk("first_strobe_cycle", n, 2);
                else          chk("strobe_gap_4_or_5", int'((n - last) == 4 || (n - last) == 5), 1);
                last = n;
                cnt++;
            end
        end
        chk("strobes_per_100clk", cnt, 24);
        chk("idle_active", int'(active_seen), 0);

        a5_packet(1.0, "clean_a5");

        idle(5);
        repeat (8) push_ev(EV_VALID, 1'b1);
        push_ev(EV_EOP, 1'b0);
        repeat (8) tx_bits.push_back(1'b1);
        send_frame(1'b1, 2);
        end_scn("stuffed_ones", 1);

        // Sixth data one is the seventh wire one after SYNC: error there, no EOP.
        idle(5);
        repeat (5) push_ev(EV_VALID, 1'b1);
        push_ev(EV_ERR, 1'b0);
        repeat (8) tx_bits.push_back(1'b1);
        send_frame(1'b0, 2);
        end_scn("missing_stuff", 1);

        a5_packet(1.0025, "slow_a5");
        a5_packet(0.9975, "fast_a5");

        idle(5);
        put(K); put(J); put(K); put(K);
        idle(3);
        put(SE0); put(SE0); put(J);
        end_scn("bad_sync", 0);

        idle(5);
        load_byte(8'h3C);
        expect_tx_bits();
        push_ev(EV_ERR, 1'b0);
        send_frame(1'b1, 5);
        end_scn("long_se0", 1);
        run_random("recover_long_se0");

        // Reset lands after the fourth decoded bit; nothing further may be reported.
        idle(5);
        push_ev(EV_VALID, 1'b1); push_ev(EV_VALID, 1'b0);
        push_ev(EV_VALID, 1'b1); push_ev(EV_VALID, 1'b0);
        load_byte(8'hA5);
        base = n_valid;
        wcnt = 0;
        fork
            send_frame(1'b1, 2);
            begin
                while (n_valid < base + 4 && wcnt < 400) begin
                    @(negedge clk50);
                    #2;
                    wcnt++;
                end
                chk("reset_wait_4_bits", int'(n_valid >= base + 4), 1);
                rst_n = 1'b0;
                #1;
                chk("async_reset_outputs", int'(outs()), 0);
                #44;
                rst_n = 1'b1;
            end
        join
        end_scn("reset_mid", 1);
        run_random("recover_reset");

        for (int i = 0; i < 20; i++) run_random($sformatf("rand%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
